// File: rtl/axi_rt_regbus_arb_pkg.sv
// Shared types and helpers for the regbus round-robin arbiter family.
// Default request/response structs are provided for standalone builds.
package axi_rt_regbus_arb_pkg;

    localparam int unsigned MaxPorts = 16;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_default_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_default_t;

    // Successor of a round-robin pointer, wrapping at num_ports.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_ports);
        return (ptr + 1 >= num_ports) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/axi_rt_regbus_rr_pick.sv
// Combinational rotate-priority selector: first set bit of valid_i at or
// above ptr_i, wrapping modulo NumPorts.
module axi_rt_regbus_rr_pick #(
    parameter int unsigned NumPorts = 2,
    localparam int unsigned IdxW = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] valid_i,
    input  logic [IdxW-1:0]     ptr_i,
    output logic [IdxW-1:0]     winner_o,
    output logic                any_valid_o
);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        winner_o    = '0;
        any_valid_o = 1'b0;
        for (int unsigned off = 0; off < NumPorts; off++) begin
            idx = 32'(ptr_i) + off;
            if (idx >= NumPorts) begin
                idx = idx - NumPorts;
            end
            if (!any_valid_o && valid_i[IdxW'(idx)]) begin
                any_valid_o = 1'b1;
                winner_o    = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/axi_rt_regbus_arbiter.sv
// Round-robin arbiter sharing one register-bus port among NumPorts requesters,
// holding the grant across ready stalls. Optional per-port grant counters are
// enabled with the AXI_RT_REGBUS_ARB_STATS_EN macro.
module axi_rt_regbus_arbiter
    import axi_rt_regbus_arb_pkg::*;
#(
    parameter int unsigned NumPorts   = 2,
    parameter int unsigned RegIdWidth = 4,
    parameter int unsigned CntWidth   = 16,
    parameter type reg_req_t = reg_req_default_t,
    parameter type reg_rsp_t = reg_rsp_default_t,
    parameter type reg_id_t  = logic [RegIdWidth-1:0]
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t req_i [NumPorts],
    output reg_rsp_t rsp_o [NumPorts],
    output reg_req_t req_o,
    input  reg_rsp_t rsp_i,
    output reg_id_t  id_o,
    output logic     busy_o
`ifdef AXI_RT_REGBUS_ARB_STATS_EN
    ,
    output logic [CntWidth-1:0] grant_cnt_o [NumPorts],
    input  logic                cnt_clear_i
`endif
);

    localparam int unsigned IdxW = $clog2(NumPorts);
    typedef logic [IdxW-1:0] idx_t;

    if (NumPorts < 2 || NumPorts > MaxPorts) begin : g_bad_ports
        $error("NumPorts must be within 2..16");
    end
    if (RegIdWidth < IdxW) begin : g_bad_idw
        $error("RegIdWidth too narrow to encode NumPorts");
    end
    if (CntWidth < 1) begin : g_bad_cntw
        $error("CntWidth must be at least 1");
    end

    arb_state_e          state_q, state_d;
    idx_t                rr_ptr_q, rr_ptr_d;
    idx_t                gnt_q, gnt_d;
    logic [NumPorts-1:0] req_valid;
    idx_t                winner;
    logic                any_valid;
    idx_t                sel;
    logic                active;

    always_comb begin
        req_valid = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            req_valid[i] = req_i[i].valid;
        end
    end

    axi_rt_regbus_rr_pick #(
        .NumPorts (NumPorts)
    ) i_rr_pick (
        .valid_i     (req_valid),
        .ptr_i       (rr_ptr_q),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    // While locked the stored grant wins regardless of new requests.
    assign sel    = (state_q == LOCKED) ? gnt_q : winner;
    assign active = (state_q == LOCKED) || any_valid;
    assign busy_o = (state_q == LOCKED);
    assign req_o  = active ? req_i[sel] : '0;
    assign id_o   = active ? reg_id_t'(sel) : '0;

    always_comb begin
        for (int unsigned i = 0; i < NumPorts; i++) begin
            rsp_o[i] = '0;
            if (active && sel == idx_t'(i)) begin
                rsp_o[i] = rsp_i;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    if (rsp_i.ready) begin
                        rr_ptr_d = idx_t'(rr_next(32'(winner), NumPorts));
                    end else begin
                        state_d = LOCKED;
                        gnt_d   = winner;
                    end
                end
            end
            LOCKED: begin
                if (rsp_i.ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = idx_t'(rr_next(32'(gnt_q), NumPorts));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
        end
    end

`ifdef AXI_RT_REGBUS_ARB_STATS_EN
    logic                done;
    logic [CntWidth-1:0] cnt_q [NumPorts];
    logic [CntWidth-1:0] cnt_d [NumPorts];

    assign done = req_o.valid && rsp_i.ready;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clear_i) begin
                cnt_d[i] = '0;
            end else if (done && sel == idx_t'(i) && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign grant_cnt_o = cnt_q;
`endif

`ifndef SYNTHESIS
    a_locked_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == LOCKED) |-> req_i[gnt_q].valid)
        else $error("locked requester dropped valid before completion");
`endif

endmodule

// File: tb/tb_axi_rt_regbus_arbiter.sv
// Scoreboard bench for axi_rt_regbus_arbiter with four requesters; the
// AXI_RT_REGBUS_ARB_STATS_EN build also exercises the grant counters.
module tb_axi_rt_regbus_arbiter;
    import axi_rt_regbus_arb_pkg::*;

    localparam int N = 4;
    localparam logic [31:0] RdDef = 32'h600d_0000;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    reg_req_default_t req [N];
    reg_rsp_default_t rsp_out [N];
    reg_req_default_t req_out;
    reg_rsp_default_t rsp_in;
    logic [3:0]       id_out;
    logic             busy;
`ifdef AXI_RT_REGBUS_ARB_STATS_EN
    logic [1:0]       gcnt [N];
    logic             cnt_clear = 1'b0;
`endif

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    axi_rt_regbus_arbiter #(
        .NumPorts   (N),
        .RegIdWidth (4),
        .CntWidth   (2)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .rsp_o   (rsp_out),
        .req_o   (req_out),
        .rsp_i   (rsp_in),
        .id_o    (id_out),
        .busy_o  (busy)
`ifdef AXI_RT_REGBUS_ARB_STATS_EN
        ,
        .grant_cnt_o (gcnt),
        .cnt_clear_i (cnt_clear)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic set_req(input int p);
        req[p].valid = 1'b1;
        req[p].addr  = 32'h100 + 32'(p) * 4;
        req[p].write = p[0];
        req[p].wdata = 32'hA000_0000 | 32'(p);
        req[p].wstrb = 4'hF;
    endtask

    task automatic push(input int p, input logic e, input logic [31:0] rd);
        exp_t x;
        x.id    = 4'(p);
        x.addr  = 32'h100 + 32'(p) * 4;
        x.err   = e;
        x.rdata = rd;
        exp_q.push_back(x);
    endtask

    // One clock; requesters whose transfer completed drop valid afterwards.
    task automatic tick();
        logic [N-1:0] done;
        @(negedge clk);
        for (int i = 0; i < N; i++) done[i] = req[i].valid && rsp_out[i].ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (done[i]) req[i].valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 30 && exp_q.size() > 0; k++) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every completed downstream transfer is matched against the queue.
    always @(negedge clk) begin
        if (rst_n && req_out.valid && rsp_in.ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_xfer: got id %0d want none", id_out);
            end else begin
                exp_t x;
                int   gi;
                logic others;
                x  = exp_q.pop_front();
                gi = int'(id_out);
                others = 1'b0;
                for (int j = 0; j < N; j++) if (j != gi) others |= |rsp_out[j];
                chk("grant_id", 32'(id_out), 32'(x.id));
                chk("fwd_addr", req_out.addr, x.addr);
                if (gi < N) begin
                    chk("rsp_err", 32'(rsp_out[gi].error), 32'(x.err));
                    chk("rsp_rdata", rsp_out[gi].rdata, x.rdata);
                end
                chk("others_zero", 32'(others), 32'd0);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) req[i] = '0;
        rsp_in = '0;
        rsp_in.ready = 1'b1;
        rsp_in.rdata = RdDef;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_id", 32'(id_out), 32'd0);
        chk("rst_req_valid", 32'(req_out.valid), 32'd0);
        chk("rst_rsp0_ready", 32'(rsp_out[0].ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ports 0 and 2, then 3 and 0 to confirm the pointer landed on 3.
        set_req(0); set_req(2);
        push(0, 1'b0, RdDef); push(2, 1'b0, RdDef);
        drain("t1");
        set_req(0); set_req(3);
        push(3, 1'b0, RdDef); push(0, 1'b0, RdDef);
        drain("t1b");

        // Port 1 stalled three cycles; port 0 arrives while locked.
        set_req(1);
        rsp_in.ready = 1'b0;
        #1;
        chk("t2_c0_id", 32'(id_out), 32'd1);
        chk("t2_c0_busy", 32'(busy), 32'd0);
        push(1, 1'b0, RdDef); push(0, 1'b0, RdDef);
        tick();
        set_req(0);
        #1;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                rsp_in.ready = 1'b1;
                #1;
            end
            chk("t2_lock_busy", 32'(busy), 32'd1);
            chk("t2_lock_id", 32'(id_out), 32'd1);
            chk("t2_lock_rsp0", 32'(rsp_out[0].ready), 32'd0);
            if (c < 3) tick();
        end
        drain("t2");

        // Error response reaches only the granted port.
        set_req(3);
        rsp_in.error = 1'b1;
        rsp_in.rdata = 32'hbadca51e;
        push(3, 1'b1, 32'hbadca51e);
        drain("t6");
        rsp_in.error = 1'b0;
        rsp_in.rdata = RdDef;

        // Reset in the middle of a locked transfer.
        set_req(2);
        rsp_in.ready = 1'b0;
        tick();
        set_req(0);
        #1;
        chk("t4_locked_id", 32'(id_out), 32'd2);
        chk("t4_locked_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_id", 32'(id_out), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_in.ready = 1'b1;
        push(0, 1'b0, RdDef); push(2, 1'b0, RdDef);
        drain("t4");

        // Fresh reset, then all four ports requesting continuously.
        for (int i = 0; i < N; i++) req[i].valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t3_idle_valid", 32'(req_out.valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) set_req(i);
            push(k % N, 1'b0, RdDef);
            tick();
        end
        for (int i = 0; i < N; i++) req[i].valid = 1'b0;
        drain("t3");

`ifdef AXI_RT_REGBUS_ARB_STATS_EN
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("cnt_cleared", 32'(gcnt[1]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            set_req(1);
            push(1, 1'b0, RdDef);
            tick();
        end
        chk("cnt_sat", 32'(gcnt[1]), 32'd3);
        chk("cnt_port0", 32'(gcnt[0]), 32'd0);
        set_req(1);
        push(1, 1'b0, RdDef);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("cnt_clear_prio", 32'(gcnt[1]), 32'd0);
        drain("stats");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
